mem_stage_pipe: RTL and testbench

- Parametrised memory stage for the 5-stage pipeline. Sits between EX/MEM and MEM/WB.
- Resolves conditional branches from the EX flags.
- Drives a request/acknowledge data-memory port that tolerates variable latency, stalling upstream while an access is pending.
- Registers results into the MEM/WB boundary.
- Successor to the fixed single-cycle 16-bit memory slice: adds width parameters, wait-state handshake, timeout/error, and a fully specified (latch-free) branch table.

---
 rtl/mem_stage_pipe.sv | 138 +++++++++++++
 tb/tb_mem_stage_pipe.sv | 226 ++++++++++++++++++++++
 2 files changed

// File: rtl/mem_stage_pipe.sv
// Memory stage between EX/MEM and MEM/WB: resolves branches, runs a req/ack
// data-memory access with wait states and timeout, and registers MEM/WB results.
module mem_stage_pipe #(
    parameter int DW      = 16,
    parameter int AW      = 16,
    parameter int WBW     = 2,
    parameter int TIMEOUT = 15
) (
    input  logic           clk,
    input  logic           rst,
    input  logic           in_valid,
    input  logic [2:0]     M,
    input  logic [WBW-1:0] WB_in,
    input  logic [2:0]     flags_in,
    input  logic [2:0]     bcond,
    input  logic [AW-1:0]  addr,
    input  logic [DW-1:0]  wdata,
    input  logic [DW-1:0]  PCbranch_in,
    input  logic [DW-1:0]  ALU_in,
    output logic           mem_req,
    output logic           mem_we,
    output logic [AW-1:0]  mem_addr,
    output logic [DW-1:0]  mem_wdata,
    input  logic           mem_ack,
    input  logic [DW-1:0]  mem_rdata,
    output logic           stall,
    output logic           Branch,
    output logic [DW-1:0]  PCbranch,
    output logic           out_valid,
    output logic [WBW-1:0] WB,
    output logic [DW-1:0]  ALU,
    output logic [DW-1:0]  rdata,
    output logic [DW-1:0]  PCret,
    output logic           mem_err
);

    localparam int CW = (TIMEOUT < 1) ? 1 : $clog2(TIMEOUT + 1);
    localparam logic [CW-1:0] CNT_MAX = CW'(TIMEOUT);

    typedef enum logic {
        S_IDLE,
        S_WAIT
    } state_t;

    state_t        state;
    logic [CW-1:0] wait_cnt;

    logic           rd, wr, mem_op, abort, adv;
    logic           vld_p1;
    logic [WBW-1:0] wb_p1;
    logic [DW-1:0]  alu_p1;
    logic [DW-1:0]  rdata_p1;

    function automatic logic branch_cond(input logic [2:0] bc, input logic [2:0] f);
        logic zr, neg, ov, c;
        zr  = f[0];
        neg = f[1];
        ov  = f[2];
        case (bc)
            3'd0:    c = zr;
            3'd1:    c = neg & ~zr;
            3'd2:    c = ~neg & ~zr;
            3'd3:    c = ov;
            3'd4:    c = ~zr;
            3'd5:    c = ~neg;
            3'd6:    c = neg | zr;
            default: c = 1'b1;
        endcase
        return c;
    endfunction

    // Decode and handshake: everything combinational is masked while rst is high
    always_comb begin
        rd      = M[0] & ~M[1] & ~M[2];
        wr      = M[1] & ~M[2];
        mem_op  = in_valid & (rd | wr) & ~rst;
        abort   = (state == S_WAIT) & mem_op & ~mem_ack & (wait_cnt == CNT_MAX);
        stall   = mem_op & ~mem_ack & ~abort;
        adv     = in_valid & ~stall & ~rst;
        Branch  = in_valid & M[2] & branch_cond(bcond, flags_in) & ~rst;
        mem_req = mem_op;
        mem_err = abort;
    end

    assign mem_we    = wr;
    assign mem_addr  = addr;
    assign mem_wdata = wdata;
    assign PCbranch  = PCbranch_in;

    // Wait-state tracker
    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= S_IDLE;
            wait_cnt <= '0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (mem_op && !mem_ack) begin
                        state    <= S_WAIT;
                        wait_cnt <= CW'(1);
                    end
                end
                default: begin
                    if (!mem_op || mem_ack || abort) begin
                        state    <= S_IDLE;
                        wait_cnt <= '0;
                    end else begin
                        wait_cnt <= wait_cnt + CW'(1);
                    end
                end
            endcase
        end
    end

    // MEM/WB boundary (p1); an aborted access squashes its writeback controls
    always_ff @(posedge clk) begin
        if (rst) begin
            vld_p1   <= 1'b0;
            wb_p1    <= '0;
            alu_p1   <= '0;
            rdata_p1 <= '0;
        end else begin
            vld_p1 <= adv;
            if (adv) begin
                wb_p1    <= abort ? '0 : WB_in;
                alu_p1   <= ALU_in;
                rdata_p1 <= (rd && mem_ack) ? mem_rdata : '0;
            end
        end
    end

    assign out_valid = vld_p1;
    assign WB        = wb_p1;
    assign ALU       = alu_p1;
    assign rdata     = rdata_p1;
    assign PCret     = rdata_p1;

endmodule

// File: tb/tb_mem_stage_pipe.sv
// Directed bench for mem_stage_pipe (TIMEOUT=4): load/store latency, branch
// table, timeout abort, reset during a pending access, back-to-back loads.
module tb_mem_stage_pipe;

    logic        clk = 1'b0;
    logic        rst, in_valid, mem_ack;
    logic [2:0]  M, flags_in, bcond;
    logic [1:0]  WB_in;
    logic [15:0] addr, wdata, PCbranch_in, ALU_in, mem_rdata;
    logic        mem_req, mem_we, stall, Branch, out_valid, mem_err;
    logic [15:0] mem_addr, mem_wdata, PCbranch, ALU, rdata, PCret;
    logic [1:0]  WB;

    int nvec = 0;
    int nerr = 0;

    always #5 clk = ~clk;

    mem_stage_pipe #(.DW(16), .AW(16), .WBW(2), .TIMEOUT(4)) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .M(M), .WB_in(WB_in),
        .flags_in(flags_in), .bcond(bcond), .addr(addr), .wdata(wdata),
        .PCbranch_in(PCbranch_in), .ALU_in(ALU_in), .mem_req(mem_req),
        .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_ack(mem_ack), .mem_rdata(mem_rdata), .stall(stall),
        .Branch(Branch), .PCbranch(PCbranch), .out_valid(out_valid), .WB(WB),
        .ALU(ALU), .rdata(rdata), .PCret(PCret), .mem_err(mem_err)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b1; in_valid = 1'b1; M = 3'b001; WB_in = 2'b11; flags_in = 3'b000;
        bcond = 3'd7; addr = 16'h0010; wdata = 16'h0; PCbranch_in = 16'h0100;
        ALU_in = 16'h1111; mem_ack = 1'b1; mem_rdata = 16'hAAAA;
        #1;
        nvec++; if (mem_req !== 1'b0) begin nerr++; $display("FAIL rst_mem_req: got %b want 0", mem_req); end
        nvec++; if (stall !== 1'b0)   begin nerr++; $display("FAIL rst_stall: got %b want 0", stall); end
        tick();
        nvec++; if (out_valid !== 1'b0) begin nerr++; $display("FAIL rst_out_valid: got %b want 0", out_valid); end
        nvec++; if ({WB, ALU, rdata, PCret} !== 50'd0) begin nerr++; $display("FAIL rst_regs: got WB=%h ALU=%h rdata=%h PCret=%h want 0", WB, ALU, rdata, PCret); end
        nvec++; if (mem_err !== 1'b0) begin nerr++; $display("FAIL rst_mem_err: got %b want 0", mem_err); end
        rst = 1'b0; in_valid = 1'b0; mem_ack = 1'b0;
        tick();
    endtask

    task automatic test_load_zero_wait();
        in_valid = 1'b1; M = 3'b001; addr = 16'h0040; WB_in = 2'b10; ALU_in = 16'h2222;
        mem_ack = 1'b1; mem_rdata = 16'hBEEF; PCbranch_in = 16'h0ABC;
        #1;
        nvec++; if (stall !== 1'b0) begin nerr++; $display("FAIL load0_stall: got %b want 0", stall); end
        nvec++; if ({mem_req, mem_we, mem_addr} !== {1'b1, 1'b0, 16'h0040}) begin nerr++; $display("FAIL load0_req: got req=%b we=%b addr=%h want 1 0 0040", mem_req, mem_we, mem_addr); end
        nvec++; if (PCbranch !== 16'h0ABC) begin nerr++; $display("FAIL pcbranch: got %h want 0abc", PCbranch); end
        tick();
        nvec++; if (out_valid !== 1'b1) begin nerr++; $display("FAIL load0_ov: got %b want 1", out_valid); end
        nvec++; if (rdata !== 16'hBEEF || PCret !== 16'hBEEF) begin nerr++; $display("FAIL load0_rdata: got rdata=%h PCret=%h want beef", rdata, PCret); end
        nvec++; if (WB !== 2'b10 || ALU !== 16'h2222) begin nerr++; $display("FAIL load0_wb_alu: got WB=%b ALU=%h want 10 2222", WB, ALU); end
        in_valid = 1'b0; mem_ack = 1'b0;
        tick();
        nvec++; if (out_valid !== 1'b0 || rdata !== 16'hBEEF) begin nerr++; $display("FAIL bubble_hold: got ov=%b rdata=%h want 0 beef", out_valid, rdata); end
    endtask

    task automatic test_store_wait();
        in_valid = 1'b1; M = 3'b010; wdata = 16'h1234; addr = 16'h0080; WB_in = 2'b01;
        mem_ack = 1'b0; mem_rdata = 16'hFFFF;
        for (int i = 1; i <= 3; i++) begin
            #1;
            nvec++; if ({stall, mem_req, mem_we} !== 3'b111) begin nerr++; $display("FAIL store_wait c%0d: got stall=%b req=%b we=%b want 111", i, stall, mem_req, mem_we); end
            nvec++; if (mem_wdata !== 16'h1234) begin nerr++; $display("FAIL store_wdata c%0d: got %h want 1234", i, mem_wdata); end
            tick();
            nvec++; if (out_valid !== 1'b0) begin nerr++; $display("FAIL store_ov_stall c%0d: got %b want 0", i, out_valid); end
        end
        mem_ack = 1'b1;
        #1;
        nvec++; if (stall !== 1'b0) begin nerr++; $display("FAIL store_ack_stall: got %b want 0", stall); end
        tick();
        nvec++; if (out_valid !== 1'b1 || rdata !== 16'h0000 || WB !== 2'b01) begin nerr++; $display("FAIL store_done: got ov=%b rdata=%h WB=%b want 1 0000 01", out_valid, rdata, WB); end
        in_valid = 1'b0; mem_ack = 1'b0;
        tick();
    endtask

    task automatic test_branch_table();
        logic zr, neg, ov, exp_c;
        in_valid = 1'b1; M = 3'b100; mem_ack = 1'b0;
        for (int b = 0; b < 8; b++) begin
            for (int f = 0; f < 8; f++) begin
                bcond = 3'(b); flags_in = 3'(f);
                zr = flags_in[0]; neg = flags_in[1]; ov = flags_in[2];
                case (b)
                    0: exp_c = zr;
                    1: exp_c = neg && !zr;
                    2: exp_c = !neg && !zr;
                    3: exp_c = ov;
                    4: exp_c = !zr;
                    5: exp_c = !neg;
                    6: exp_c = neg || zr;
                    default: exp_c = 1'b1;
                endcase
                #1;
                nvec++; if (Branch !== exp_c) begin nerr++; $display("FAIL branch b%0d f%0d: got %b want %b", b, f, Branch, exp_c); end
                nvec++; if (mem_req !== 1'b0 || stall !== 1'b0) begin nerr++; $display("FAIL branch_nomem b%0d f%0d: got req=%b stall=%b want 0 0", b, f, mem_req, stall); end
            end
        end
        M = 3'b111; bcond = 3'd7;
        #1;
        nvec++; if (Branch !== 1'b1 || mem_req !== 1'b0) begin nerr++; $display("FAIL branch_m111: got br=%b req=%b want 1 0", Branch, mem_req); end
        in_valid = 1'b0;
        #1;
        nvec++; if (Branch !== 1'b0) begin nerr++; $display("FAIL branch_invalid: got %b want 0", Branch); end
        tick();
    endtask

    task automatic test_timeout();
        in_valid = 1'b1; M = 3'b001; WB_in = 2'b11; ALU_in = 16'h3333;
        mem_ack = 1'b0; mem_rdata = 16'hDEAD;
        for (int i = 1; i <= 4; i++) begin
            #1;
            nvec++; if (stall !== 1'b1 || mem_err !== 1'b0) begin nerr++; $display("FAIL tmo_wait c%0d: got stall=%b err=%b want 1 0", i, stall, mem_err); end
            tick();
            nvec++; if (out_valid !== 1'b0) begin nerr++; $display("FAIL tmo_ov c%0d: got %b want 0", i, out_valid); end
        end
        #1;
        nvec++; if (stall !== 1'b0 || mem_err !== 1'b1) begin nerr++; $display("FAIL tmo_abort: got stall=%b err=%b want 0 1", stall, mem_err); end
        tick();
        nvec++; if (out_valid !== 1'b1 || WB !== 2'b00 || rdata !== 16'h0 || ALU !== 16'h3333) begin nerr++; $display("FAIL tmo_squash: got ov=%b WB=%b rdata=%h ALU=%h want 1 00 0000 3333", out_valid, WB, rdata, ALU); end
        // A fresh load must see the full wait budget again
        for (int i = 1; i <= 2; i++) begin
            #1;
            nvec++; if (stall !== 1'b1 || mem_err !== 1'b0) begin nerr++; $display("FAIL tmo_idle c%0d: got stall=%b err=%b want 1 0", i, stall, mem_err); end
            tick();
        end
        mem_ack = 1'b1; mem_rdata = 16'h7777;
        tick();
        nvec++; if (out_valid !== 1'b1 || rdata !== 16'h7777 || WB !== 2'b11) begin nerr++; $display("FAIL tmo_recover: got ov=%b rdata=%h WB=%b want 1 7777 11", out_valid, rdata, WB); end
        mem_ack = 1'b0; in_valid = 1'b0;
    endtask

    task automatic test_reset_mid_wait();
        in_valid = 1'b1; M = 3'b001; mem_ack = 1'b0; WB_in = 2'b10; ALU_in = 16'h4444;
        tick();
        tick();
        rst = 1'b1;
        #1;
        nvec++; if (mem_req !== 1'b0 || stall !== 1'b0 || mem_err !== 1'b0) begin nerr++; $display("FAIL rstw_comb: got req=%b stall=%b err=%b want 0 0 0", mem_req, stall, mem_err); end
        tick();
        nvec++; if ({out_valid, WB, ALU, rdata, PCret} !== 51'd0) begin nerr++; $display("FAIL rstw_regs: got ov=%b WB=%b ALU=%h rdata=%h PCret=%h want 0", out_valid, WB, ALU, rdata, PCret); end
        rst = 1'b0; mem_ack = 1'b1; mem_rdata = 16'h5A5A;
        #1;
        nvec++; if (stall !== 1'b0 || mem_req !== 1'b1) begin nerr++; $display("FAIL rstw_load: got stall=%b req=%b want 0 1", stall, mem_req); end
        tick();
        nvec++; if (out_valid !== 1'b1 || rdata !== 16'h5A5A) begin nerr++; $display("FAIL rstw_done: got ov=%b rdata=%h want 1 5a5a", out_valid, rdata); end
        in_valid = 1'b0; mem_ack = 1'b0;
        tick();
    endtask

    task automatic test_boundaries();
        // stray ack without a request
        in_valid = 1'b0; M = 3'b001; mem_ack = 1'b1;
        #1;
        nvec++; if (mem_req !== 1'b0 || stall !== 1'b0) begin nerr++; $display("FAIL stray_ack: got req=%b stall=%b want 0 0", mem_req, stall); end
        tick();
        // in_valid drops while waiting; next load gets the full budget
        in_valid = 1'b1; mem_ack = 1'b0;
        tick();
        tick();
        in_valid = 1'b0;
        #1;
        nvec++; if (mem_err !== 1'b0 || stall !== 1'b0) begin nerr++; $display("FAIL drop_wait: got err=%b stall=%b want 0 0", mem_err, stall); end
        tick();
        in_valid = 1'b1;
        for (int i = 1; i <= 4; i++) begin
            #1;
            nvec++; if (stall !== 1'b1 || mem_err !== 1'b0) begin nerr++; $display("FAIL drop_relaunch c%0d: got stall=%b err=%b want 1 0", i, stall, mem_err); end
            tick();
        end
        mem_ack = 1'b1;
        tick();
        // read+write acts as a write
        M = 3'b011; mem_rdata = 16'hC0DE;
        #1;
        nvec++; if (mem_we !== 1'b1 || mem_req !== 1'b1) begin nerr++; $display("FAIL rw_we: got we=%b req=%b want 1 1", mem_we, mem_req); end
        tick();
        nvec++; if (out_valid !== 1'b1 || rdata !== 16'h0) begin nerr++; $display("FAIL rw_rdata: got ov=%b rdata=%h want 1 0000", out_valid, rdata); end
        in_valid = 1'b0; mem_ack = 1'b0;
        tick();
    endtask

    task automatic test_back_to_back();
        logic [15:0] exp_rd [5];
        logic        exp_ov [5];
        logic        ack_seq [5];
        logic [15:0] dat_seq [5];
        int          ov_cnt;
        ack_seq = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b1};
        dat_seq = '{16'hA001, 16'h0, 16'h0, 16'hA002, 16'hA003};
        exp_ov  = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b1};
        exp_rd  = '{16'hA001, 16'hA001, 16'hA001, 16'hA002, 16'hA003};
        ov_cnt = 0;
        in_valid = 1'b1; M = 3'b001;
        for (int c = 0; c < 5; c++) begin
            mem_ack = ack_seq[c]; mem_rdata = dat_seq[c];
            tick();
            if (out_valid === 1'b1) ov_cnt++;
            nvec++; if (out_valid !== exp_ov[c] || rdata !== exp_rd[c]) begin nerr++; $display("FAIL b2b c%0d: got ov=%b rdata=%h want %b %h", c, out_valid, rdata, exp_ov[c], exp_rd[c]); end
        end
        in_valid = 1'b0; mem_ack = 1'b0;
        tick();
        nvec++; if (out_valid !== 1'b0 || ov_cnt != 3) begin nerr++; $display("FAIL b2b_count: got ov=%b count=%0d want 0 3", out_valid, ov_cnt); end
    endtask

    initial begin
        test_reset();
        test_load_zero_wait();
        test_store_wait();
        test_branch_table();
        test_timeout();
        test_reset_mid_wait();
        test_boundaries();
        test_back_to_back();
        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end

endmodule
